nonrestoring_divider: RTL and testbench

- Sequential radix-2 non-restoring integer divider with its own controller and datapath.
- It performs the inverse of the Booth multiplier: it takes a dividend and divisor and returns quotient and remainder.
- It uses the same start/done handshake and is intended to sit beside the multiplier in the arithmetic unit.

---
 rtl/nonrestoring_divider_if.sv | 24 ++
 rtl/nonrestoring_divider.sv | 155 +++++++++++++++
 tb/tb_nonrestoring_divider.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/nonrestoring_divider_if.sv
// Handshake and operand/result bus for the non-restoring divider.
// The requester drives the master modport, the divider uses the slave modport.
interface nonrestoring_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/nonrestoring_divider.sv
// Sequential radix-2 non-restoring divider with start/done handshake.
// Optional macro SIGNED_DIV_EN enables two's-complement operands via an extra SIGN state.
module nonrestoring_divider #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input logic                   clk,
    input logic                   rst_n,
    nonrestoring_divider_if.slave bus
);

`ifdef SIGNED_DIV_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ITER, S_FIX, S_SIGN, S_DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ITER, S_FIX, S_DONE
    } state_t;
`endif

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_A;
    logic [WIDTH-1:0] r_Q;
    logic [WIDTH-1:0] r_M;
    logic             r_divZero;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
`ifdef SIGNED_DIV_EN
    logic             r_signQ;
    logic             r_signR;
`endif

    logic             w_accept;
    logic [WIDTH-1:0] w_loadQ;
    logic [WIDTH-1:0] w_loadM;
    logic [WIDTH:0]   w_mExt;
    logic [WIDTH:0]   w_aShift;
    logic [WIDTH:0]   w_aIter;
    logic [WIDTH:0]   w_aFix;

    assign w_accept = bus.start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_mExt   = {1'b0, r_M};
    assign w_aShift = {r_A[WIDTH-1:0], r_Q[WIDTH-1]};
    assign w_aIter  = r_A[WIDTH] ? (w_aShift + w_mExt) : (w_aShift - w_mExt);
    assign w_aFix   = r_A[WIDTH] ? (r_A + w_mExt) : r_A;

    // A zero divisor keeps the raw dividend in Q so it can be returned as the remainder.
    always_comb begin
        w_loadQ = bus.dividend;
        w_loadM = bus.divisor;
`ifdef SIGNED_DIV_EN
        if (bus.divisor != '0 && bus.dividend[WIDTH-1])
            w_loadQ = ~bus.dividend + WIDTH'(1);
        if (bus.divisor[WIDTH-1])
            w_loadM = ~bus.divisor + WIDTH'(1);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_A         <= '0;
            r_Q         <= '0;
            r_M         <= '0;
            r_divZero   <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
`ifdef SIGNED_DIV_EN
            r_signQ     <= 1'b0;
            r_signR     <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    r_state <= bus.start ? S_LOAD : S_IDLE;
                    r_busy  <= bus.start;
                end
                // Divide-by-zero skips the iterations but still passes through FIX.
                S_LOAD: begin
                    r_divZero <= (r_M == '0);
                    r_state   <= (r_M == '0) ? S_FIX : S_ITER;
                end
                S_ITER: begin
                    r_A   <= w_aIter;
                    r_Q   <= {r_Q[WIDTH-2:0], ~w_aIter[WIDTH]};
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1))
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    if (r_divZero) begin
                        r_quotient  <= '1;
                        r_remainder <= r_Q;
                        r_dbz       <= 1'b1;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_A <= w_aFix;
`ifdef SIGNED_DIV_EN
                        r_state <= S_SIGN;
`else
                        r_quotient  <= r_Q;
                        r_remainder <= w_aFix[WIDTH-1:0];
                        r_dbz       <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
`endif
                    end
                end
`ifdef SIGNED_DIV_EN
                // C-style truncation: remainder takes the sign of the dividend.
                S_SIGN: begin
                    r_quotient  <= r_signQ ? (~r_Q + WIDTH'(1)) : r_Q;
                    r_remainder <= r_signR ? (~r_A[WIDTH-1:0] + WIDTH'(1)) : r_A[WIDTH-1:0];
                    r_dbz       <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b1;
                    r_state     <= S_DONE;
                end
`endif
                default: r_state <= S_IDLE;
            endcase

            if (w_accept) begin
                r_Q   <= w_loadQ;
                r_M   <= w_loadM;
                r_A   <= '0;
                r_cnt <= CNT_W'(WIDTH);
`ifdef SIGNED_DIV_EN
                r_signQ <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                r_signR <= bus.dividend[WIDTH-1];
`endif
            end
        end
    end

    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Self-checking bench for nonrestoring_divider: directed cases plus random operands
// compared against a plain-arithmetic reference model (signed when SIGNED_DIV_EN is defined).
module tb_nonrestoring_divider;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    nonrestoring_divider_if #(.WIDTH(W)) bus ();

    nonrestoring_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected results and latency straight from the arithmetic definition.
    task automatic refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic [W-1:0] q, output logic [W-1:0] r,
                            output logic dz, output int lat);
`ifdef SIGNED_DIV_EN
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
`endif
        if (b == '0) begin
            q   = '1;
            r   = a;
            dz  = 1'b1;
            lat = 2;
        end else begin
`ifdef SIGNED_DIV_EN
            q   = W'(sa / sb);
            r   = W'(sa % sb);
            lat = W + 3;
`else
            q   = a / b;
            r   = a % b;
            lat = W + 2;
`endif
            dz  = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        tick();
        bus.start = 1'b0;
    endtask

    // Called just after the accepting edge; lat=-1 means done never arrived.
    task automatic waitDone(output int lat, output int busyCnt);
        busyCnt = bus.busy ? 1 : 0;
        lat     = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (bus.done) begin
                lat = k;
                break;
            end
            if (bus.busy) busyCnt++;
        end
    endtask

    task automatic checkResult(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                               input int lat, input int busyCnt);
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           expLat;
        refModel(a, b, q, r, dz, expLat);
        checkOutput({tag, "_latency"}, lat, expLat);
        checkOutput({tag, "_busycycles"}, busyCnt, expLat);
        checkOutput({tag, "_quotient"}, bus.quotient, q);
        checkOutput({tag, "_remainder"}, bus.remainder, r);
        checkOutput({tag, "_dbz"}, bus.div_by_zero, dz);
    endtask

    task automatic runOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        int lat;
        int busyCnt;
        applyStimulus(a, b);
        waitDone(lat, busyCnt);
        checkResult(tag, a, b, lat, busyCnt);
        tick();
        checkOutput({tag, "_donepulse"}, bus.done, 1'b0);
    endtask

    initial begin
        int lat;
        int busyCnt;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        tick();
        tick();
        checkOutput("rst_quotient", bus.quotient, 0);
        checkOutput("rst_remainder", bus.remainder, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_done", bus.done, 0);
        checkOutput("rst_dbz", bus.div_by_zero, 0);
        rst_n = 1'b1;
        tick();

        runOp("d100_7", 8'd100, 8'd7);
        runOp("d255_1", 8'd255, 8'd1);
        runOp("d5_9", 8'd5, 8'd9);
        runOp("d13_0", 8'd13, 8'd0);
        runOp("d6_3", 8'd6, 8'd3);

        // Start held high with operands changing mid-operation, then a back-to-back accept.
        bus.start    = 1'b1;
        bus.dividend = 8'd50;
        bus.divisor  = 8'd6;
        tick();
        bus.dividend = 8'd77;
        bus.divisor  = 8'd5;
        waitDone(lat, busyCnt);
        checkResult("held_first", 8'd50, 8'd6, lat, busyCnt);
        tick();
        bus.start = 1'b0;
        waitDone(lat, busyCnt);
        checkResult("held_second", 8'd77, 8'd5, lat, busyCnt);
        tick();

        // Reset during the fourth iteration cycle.
        applyStimulus(8'd100, 8'd7);
        repeat (4) tick();
        checkOutput("midrst_busy_before", bus.busy, 1);
        rst_n = 1'b0;
        tick();
        checkOutput("midrst_quotient", bus.quotient, 0);
        checkOutput("midrst_remainder", bus.remainder, 0);
        checkOutput("midrst_busy", bus.busy, 0);
        checkOutput("midrst_done", bus.done, 0);
        checkOutput("midrst_dbz", bus.div_by_zero, 0);
        rst_n = 1'b1;
        tick();
        checkOutput("midrst_idle", bus.busy, 0);
        runOp("d200_16", 8'd200, 8'd16);

`ifdef SIGNED_DIV_EN
        runOp("s_m100_7", 8'h9C, 8'h07);
        runOp("s_m128_m1", 8'h80, 8'hFF);
        runOp("s_m13_0", 8'hF3, 8'h00);
`endif

        for (int i = 0; i < 25; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(0, 255));
            runOp($sformatf("rand%0d", i), ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
